// File: rtl/pipelined_addsub.sv
// Pipelined two's-complement adder/subtractor. Each stage adds one WIDTH/STAGES-bit
// slice and registers the carry. Valid/ready flow control stalls the whole pipe together.
module pipelined_addsub #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             mode,
    input  logic             sat,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             of
);
    localparam int WS = WIDTH / STAGES;

    logic             w_en;
    logic             w_accept;
    logic [WIDTH-1:0] w_b_eff;
    logic             r_out_valid;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;
    logic             r_of;

    assign w_en      = ~r_out_valid | out_ready;
    assign in_ready  = w_en & ~rst;
    assign w_accept  = in_valid & in_ready;
    assign w_b_eff   = b ^ {WIDTH{mode}};

    assign out_valid = r_out_valid;
    assign sum       = r_sum;
    assign cout      = r_cout;
    assign of        = r_of;

    for (genvar k = 0; k < STAGES; k++) begin : g_stg
        localparam int LW = k * WS;
        localparam int RW = WIDTH - LW;

        logic [RW-1:0]    w_a_i;
        logic [RW-1:0]    w_b_i;
        logic             w_c_i;
        logic             w_sat_i;
        logic             w_v_i;
        logic [WS:0]      w_slice;
        logic [LW+WS-1:0] w_res_o;

        // Operands still to be added; the current slice sits in the low WS bits.
        if (k == 0) begin : g_src
            assign w_a_i   = a;
            assign w_b_i   = w_b_eff;
            assign w_c_i   = mode;
            assign w_sat_i = sat;
            assign w_v_i   = w_accept;
            assign w_res_o = w_slice[WS-1:0];
        end else begin : g_src
            assign w_a_i   = g_stg[k-1].g_fwd.r_a;
            assign w_b_i   = g_stg[k-1].g_fwd.r_b;
            assign w_c_i   = g_stg[k-1].g_fwd.r_c;
            assign w_sat_i = g_stg[k-1].g_fwd.r_sat;
            assign w_v_i   = g_stg[k-1].g_fwd.r_v;
            assign w_res_o = {w_slice[WS-1:0], g_stg[k-1].g_fwd.r_res};
        end

        assign w_slice = {1'b0, w_a_i[WS-1:0]} + {1'b0, w_b_i[WS-1:0]} + {{WS{1'b0}}, w_c_i};

        if (k < STAGES - 1) begin : g_fwd
            logic [RW-WS-1:0] r_a;
            logic [RW-WS-1:0] r_b;
            logic [LW+WS-1:0] r_res;
            logic             r_c;
            logic             r_sat;
            logic             r_v;

            // Intermediate stage register: partial result, carry and remaining slices.
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_a   <= '0;
                    r_b   <= '0;
                    r_res <= '0;
                    r_c   <= 1'b0;
                    r_sat <= 1'b0;
                    r_v   <= 1'b0;
                end else if (w_en) begin
                    r_a   <= w_a_i[RW-1:WS];
                    r_b   <= w_b_i[RW-1:WS];
                    r_res <= w_res_o;
                    r_c   <= w_slice[WS];
                    r_sat <= w_sat_i;
                    r_v   <= w_v_i;
                end else begin
                    r_a   <= r_a;
                    r_b   <= r_b;
                    r_res <= r_res;
                    r_c   <= r_c;
                    r_sat <= r_sat;
                    r_v   <= r_v;
                end
            end
        end else begin : g_last
            logic             w_cout;
            logic             w_of;
            logic [WIDTH-1:0] w_sum;

            // Operand signs agree but the raw result sign differs: same as carry-in ^ carry-out of the MSB.
            assign w_cout = w_slice[WS];
            assign w_of   = (w_a_i[WS-1] == w_b_i[WS-1]) & (w_res_o[WIDTH-1] != w_a_i[WS-1]);

            // Clamp toward the sign of a when saturation is requested.
            always_comb begin
                w_sum = w_res_o;
                if (w_sat_i & w_of) begin
                    w_sum = {w_a_i[WS-1], {(WIDTH-1){~w_a_i[WS-1]}}};
                end else begin
                    w_sum = w_res_o;
                end
            end

            // Output stage register; holds while the consumer stalls.
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_out_valid <= 1'b0;
                    r_sum       <= '0;
                    r_cout      <= 1'b0;
                    r_of        <= 1'b0;
                end else if (w_en) begin
                    r_out_valid <= w_v_i;
                    r_sum       <= w_sum;
                    r_cout      <= w_cout;
                    r_of        <= w_of;
                end else begin
                    r_out_valid <= r_out_valid;
                    r_sum       <= r_sum;
                    r_cout      <= r_cout;
                    r_of        <= r_of;
                end
            end
        end
    end

endmodule

// File: tb/tb_pipelined_addsub.sv
// Self-checking bench for pipelined_addsub: directed corner cases, backpressure,
// mid-stream reset and a randomized regression against an arithmetic reference model.
module tb_pipelined_addsub;
    localparam int WIDTH  = 16;
    localparam int STAGES = 4;

    typedef struct {
        logic [15:0] sum;
        logic        cout;
        logic        of;
        int          acc_cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        mode;
    logic        sat;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] sum;
    logic        cout;
    logic        of;

    int   cmp_cnt = 0;
    int   err_cnt = 0;
    int   cyc     = 0;
    exp_t exp_q[$];
    bit   chk_lat = 1'b1;
    bit   prev_stall = 1'b0;
    logic [15:0] prev_sum;
    logic        prev_cout;
    logic        prev_of;
    exp_t        none_e;

    always #5 clk = ~clk;

    pipelined_addsub #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a        (a),
        .b        (b),
        .mode     (mode),
        .sat      (sat),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .sum      (sum),
        .cout     (cout),
        .of       (of)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
        cmp_cnt++;
        if (got !== want) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, want, cyc);
        end
    endtask

    // Reference: signed integer arithmetic, then range test and clamp.
    function automatic exp_t model(input logic [15:0] x, input logic [15:0] y, input logic m, input logic s);
        exp_t e;
        int   sx;
        int   sy;
        int   ux;
        int   uy;
        int   r;
        sx = $signed(x);
        sy = $signed(y);
        ux = {16'd0, x};
        uy = {16'd0, y};
        r  = m ? (sx - sy) : (sx + sy);
        e.of   = (r > 32767) || (r < -32768);
        e.cout = m ? (ux >= uy) : ((ux + uy) > 65535);
        if (s && e.of) e.sum = (r > 0) ? 16'h7FFF : 16'h8000;
        else           e.sum = r[15:0];
        e.acc_cyc = 0;
        return e;
    endfunction

    task automatic drive_cycle(input logic r, input logic v, input logic [15:0] xa, input logic [15:0] xb,
                               input logic m, input logic s, input logic ordy,
                               input bit use_ovr, input exp_t ovr, output bit acc);
        exp_t e;
        @(negedge clk);
        cyc++;
        rst = r; in_valid = v; a = xa; b = xb; mode = m; sat = s; out_ready = ordy;
        #1;
        acc = 1'b0;
        check_val("in_ready", {31'd0, in_ready}, {31'd0, (!r && (!out_valid || ordy))});
        if (prev_stall) begin
            check_val("stall_valid", {31'd0, out_valid}, 32'd1);
            check_val("stall_sum", {16'd0, sum}, {16'd0, prev_sum});
            check_val("stall_cout", {31'd0, cout}, {31'd0, prev_cout});
            check_val("stall_of", {31'd0, of}, {31'd0, prev_of});
        end
        if (out_valid && ordy && !r) begin
            if (exp_q.size() == 0) begin
                check_val("unexpected_beat", {31'd0, out_valid}, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check_val("sum", {16'd0, sum}, {16'd0, e.sum});
                check_val("cout", {31'd0, cout}, {31'd0, e.cout});
                check_val("of", {31'd0, of}, {31'd0, e.of});
                if (chk_lat) check_val("latency", cyc - e.acc_cyc, STAGES);
            end
        end
        if (v && in_ready && !r) begin
            e = use_ovr ? ovr : model(xa, xb, m, s);
            e.acc_cyc = cyc;
            exp_q.push_back(e);
            acc = 1'b1;
        end
        if (r) exp_q.delete();
        prev_stall = out_valid && !ordy && !r;
        prev_sum   = sum;
        prev_cout  = cout;
        prev_of    = of;
    endtask

    task automatic idle(input int n);
        bit acc;
        for (int i = 0; i < n; i++) drive_cycle(1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1, 1'b0, none_e, acc);
    endtask

    task automatic drain(input int max_cyc);
        int n = 0;
        while (exp_q.size() != 0 && n < max_cyc) begin
            idle(1);
            n++;
        end
        check_val("drain_left", exp_q.size(), 32'd0);
    endtask

    logic [15:0] d_a   [7] = '{16'h7FFF, 16'h7FFF, 16'h8000, 16'h0005, 16'h8000, 16'hFFFF, 16'h0000};
    logic [15:0] d_b   [7] = '{16'h0001, 16'h0001, 16'hFFFF, 16'h0007, 16'h0001, 16'h0001, 16'h0001};
    logic        d_m   [7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    logic        d_s   [7] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    logic [15:0] d_sum [7] = '{16'h8000, 16'h7FFF, 16'h8000, 16'hFFFE, 16'h8000, 16'h0000, 16'hFFFF};
    logic        d_co  [7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    logic        d_of  [7] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};

    initial begin
        exp_t        e;
        bit          acc;
        int          sent;
        int          it;
        logic [15:0] ra;
        logic [15:0] rb;
        logic        rm;
        logic        rs;

        none_e = '{sum: 16'h0, cout: 1'b0, of: 1'b0, acc_cyc: 0};
        rst = 1'b1; in_valid = 1'b0; a = 16'h0; b = 16'h0; mode = 1'b0; sat = 1'b0; out_ready = 1'b1;

        for (int i = 0; i < 2; i++) drive_cycle(1'b1, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1, 1'b0, none_e, acc);
        idle(1);
        check_val("reset_out_valid", {31'd0, out_valid}, 32'd0);
        check_val("reset_sum", {16'd0, sum}, 32'd0);
        check_val("reset_cout", {31'd0, cout}, 32'd0);
        check_val("reset_of", {31'd0, of}, 32'd0);

        // Directed corner cases streamed back-to-back with fixed expectations.
        for (int i = 0; i < 7; i++) begin
            e = '{sum: d_sum[i], cout: d_co[i], of: d_of[i], acc_cyc: 0};
            drive_cycle(1'b0, 1'b1, d_a[i], d_b[i], d_m[i], d_s[i], 1'b1, 1'b1, e, acc);
            check_val("directed_accept", {31'd0, acc}, 32'd1);
        end
        drain(20);

        // Backpressure: 10 random beats, consumer stalls 3 cycles when output first appears.
        chk_lat = 1'b0;
        sent = 0;
        it   = 0;
        ra = 16'($urandom); rb = 16'($urandom); rm = 1'($urandom); rs = 1'($urandom);
        while (it < 60) begin
            drive_cycle(1'b0, (sent < 10), ra, rb, rm, rs, !(it >= STAGES && it < STAGES + 3),
                        1'b0, none_e, acc);
            if (acc) begin
                sent++;
                ra = 16'($urandom); rb = 16'($urandom); rm = 1'($urandom); rs = 1'($urandom);
            end
            it++;
            if (sent == 10 && exp_q.size() == 0) break;
        end
        check_val("bp_sent", sent, 32'd10);
        drain(20);

        // Reset with three beats in flight; nothing stale may emerge afterwards.
        chk_lat = 1'b1;
        for (int i = 0; i < 3; i++) drive_cycle(1'b0, 1'b1, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), 1'b1, 1'b0, none_e, acc);
        drive_cycle(1'b1, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1, 1'b0, none_e, acc);
        idle(1);
        check_val("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
        check_val("mid_rst_sum", {16'd0, sum}, 32'd0);
        check_val("mid_rst_cout", {31'd0, cout}, 32'd0);
        check_val("mid_rst_of", {31'd0, of}, 32'd0);
        idle(6);
        drive_cycle(1'b0, 1'b1, 16'h1234, 16'h0FFF, 1'b0, 1'b0, 1'b1, 1'b0, none_e, acc);
        check_val("post_rst_accept", {31'd0, acc}, 32'd1);
        drain(20);

        // Random regression with random in_valid and out_ready.
        chk_lat = 1'b0;
        sent = 0;
        it   = 0;
        ra = 16'($urandom); rb = 16'($urandom); rm = 1'($urandom); rs = 1'($urandom);
        while (sent < 10000 && it < 60000) begin
            drive_cycle(1'b0, ($urandom_range(0, 3) != 0), ra, rb, rm, rs, ($urandom_range(0, 9) < 7),
                        1'b0, none_e, acc);
            if (acc) begin
                sent++;
                ra = 16'($urandom); rb = 16'($urandom); rm = 1'($urandom); rs = 1'($urandom);
            end
            it++;
        end
        check_val("rand_sent", sent, 32'd10000);
        drain(40);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/pipelined_addsub.md
# pipelined_addsub

Parametrised, pipelined two's-complement adder/subtractor that succeeds the 16-bit ripple-carry adder/subtractor. Each pipeline stage computes one WIDTH/STAGES-bit slice and passes the carry forward, so operating frequency scales with slice width rather than full word width. Adds a valid/ready stream handshake with backpressure and an optional signed-saturation mode. Sits in the datapath between operand-fetch logic and any downstream consumer that needs registered, flow-controlled arithmetic results.

## Interface
- WIDTH, 16, operand/result width in bits; ≥ 2.
- STAGES, 4, pipeline depth; 1 ≤ STAGES ≤ WIDTH, and WIDTH % STAGES == 0; slice width W_S = WIDTH/STAGES.
- clk  input  1  single clock, all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operand beat valid.
- in_ready  output  1  block can accept a beat this cycle.
- a  input  WIDTH  operand A, two's complement.
- b  input  WIDTH  operand B, two's complement.
- mode  input  1  0 = a + b, 1 = a − b.
- sat  input  1  1 = clamp signed overflow to the signed min/max.
- out_valid  output  1  result beat valid.
- out_ready  input  1  consumer accepts the result this cycle.
- sum  output  WIDTH  result; raw, or saturated when sat = 1.
- cout  output  1  raw carry out of the MSB. For subtract, 1 means no borrow.
- of  output  1  raw signed overflow (carry into MSB XOR carry out of MSB), independent of sat.

## Operation
- Subtract is implemented as a + ~b + 1: stage 0 carry-in = mode, and b is inverted when mode = 1.
- Stage k adds slice k (bits k·W_S … k·W_S+W_S−1) with the carry registered from stage k−1.
  - Stage k registers: the accumulated low result bits, the unprocessed upper slices of a and the (conditionally inverted) b, the carry, sat, and a[WIDTH−1].
- Final stage:
  - Computes cout and of from the carry into and out of bit WIDTH−1.
  - If sat = 1 and of = 1, sum = a[WIDTH−1] ? {1, 0…0} : {0, 1…1}. Otherwise sum = raw result mod 2^WIDTH.
- Per-stage valid bit v[k]. Global advance enable: en = ~out_valid | out_ready.
  - When en = 1, every stage register loads from its predecessor.
  - Stage 0 loads v[0] = in_valid & in_ready.
- in_ready = en & ~rst. A beat is accepted when in_valid & in_ready.
- Output registers (sum, cout, of, out_valid) are the last stage. They hold stable while out_valid & ~out_ready.
- No control FSM: occupancy is the valid-bit shift chain. Up to STAGES beats in flight; order preserved; no beat dropped or duplicated.

## Timing
- Latency: a beat accepted at edge n appears with out_valid = 1 after edge n+STAGES−1, i.e. STAGES cycles from acceptance, provided en stays 1.
- Throughput: 1 beat/cycle while out_ready = 1.
- Stall: out_valid = 1 and out_ready = 0 freezes the whole pipeline and drives in_ready = 0 in the same cycle (combinational). Bubbles are not compressed while stalled.
- Simultaneous accept and emit in one cycle is legal and required for full throughput.
- Reset: rst sampled high at an edge clears all valid bits, out_valid, sum, cout and of to 0. In-flight beats are discarded and none are emitted. in_ready = 0 while rst = 1 and 1 on the first cycle after rst deasserts.
- a, b, mode and sat are ignored when the beat is not accepted.
- With STAGES = 1 the block is a single registered full-width adder with latency 1.

## Test plan
All cases use WIDTH = 16, STAGES = 4, out_ready = 1 unless stated.
- Add, overflow without clamp: a = 0x7FFF, b = 0x0001, mode = 0, sat = 0 → 4 cycles later sum = 0x8000, cout = 0, of = 1.
- Add with clamp: same operands, sat = 1 → sum = 0x7FFF, of = 1, cout = 0. Then a = 0x8000, b = 0xFFFF → sum = 0x8000, cout = 1, of = 1.
- Subtract: a = 0x0005, b = 0x0007, mode = 1 → sum = 0xFFFE, cout = 0, of = 0. Then a = 0x8000, b = 0x0001, sat = 1 → sum = 0x8000 (raw 0x7FFF), cout = 1, of = 1.
- Carry across every slice boundary: a = 0xFFFF, b = 0x0001, mode = 0 → sum = 0x0000, cout = 1, of = 0. Then a = 0x0000, b = 0x0001, mode = 1 → sum = 0xFFFF, cout = 0, of = 0.
- Backpressure: stream 10 back-to-back random beats; hold out_ready = 0 for 3 cycles once out_valid rises.
  - in_ready = 0 during the stall and sum holds stable.
  - All 10 results match a golden model, in order, with no loss or duplication.
- Reset mid-stream: 3 beats in flight, pulse rst for 1 cycle → next cycle out_valid = 0, sum = 0, cout = 0, of = 0. No stale beat ever appears. The first beat accepted after reset emerges 4 cycles later with the correct value.
- Random regression: 10 000 random {a, b, mode, sat} beats with random out_ready → every sum, cout and of matches the golden model.
